// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared FSM state, owner encoding and watchdog default for the
//            two-port SDRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int c_default_timeout = 255;

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Brief    : Round-robin arbiter sharing one SDRAM controller port between the
//            fetch and data paths, with a watchdog that aborts hung transfers.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_mask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                err,
    output logic                sd_req,
    output logic                sd_we,
    output logic [ADDR_W-1:0]   sd_addr,
    output logic [DATA_W-1:0]   sd_wdata,
    output logic [DATA_W/8-1:0] sd_mask,
    input  logic [DATA_W-1:0]   sd_rdata,
    input  logic                sd_ack
);

    localparam int c_mask_w = DATA_W / 8;
    localparam int c_wd_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);
    localparam logic [c_wd_w-1:0] c_wd_max  = c_wd_w'(TIMEOUT);
    localparam logic [c_wd_w-1:0] c_wd_one  = c_wd_w'(1);

    arb_state_t           r_state;
    owner_t               r_last_grant;
    logic [c_wd_w-1:0]    r_wdog;
    logic                 r_i_ack;
    logic                 r_d_ack;
    logic                 r_err;
    logic [DATA_W-1:0]    r_i_rdata;
    logic [DATA_W-1:0]    r_d_rdata;
    logic                 r_sd_req;
    logic                 r_sd_we;
    logic [ADDR_W-1:0]    r_sd_addr;
    logic [DATA_W-1:0]    r_sd_wdata;
    logic [c_mask_w-1:0]  r_sd_mask;

    logic                 w_pick_d;

    // Data wins when alone, or under contention when fetch was served last.
    assign w_pick_d = d_req && (!i_req || (r_last_grant == OWN_I));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= OWN_I;
            r_wdog       <= '0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_err        <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_sd_req     <= 1'b0;
            r_sd_we      <= 1'b0;
            r_sd_addr    <= '0;
            r_sd_wdata   <= '0;
            r_sd_mask    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wdog <= '0;
                    if (w_pick_d) begin
                        r_state      <= ST_GRANT_D;
                        r_last_grant <= OWN_D;
                        r_sd_req     <= 1'b1;
                        r_sd_we      <= d_we;
                        r_sd_addr    <= d_addr;
                        r_sd_wdata   <= d_wdata;
                        r_sd_mask    <= d_mask;
                    end else if (i_req) begin
                        r_state      <= ST_GRANT_I;
                        r_last_grant <= OWN_I;
                        r_sd_req     <= 1'b1;
                        r_sd_we      <= 1'b0;
                        r_sd_addr    <= i_addr;
                        r_sd_wdata   <= '0;
                        r_sd_mask    <= '1;
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    if (sd_ack) begin
                        r_state  <= ST_RESP;
                        r_sd_req <= 1'b0;
                        r_err    <= 1'b0;
                        if (r_state == ST_GRANT_I) begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= sd_rdata;
                        end else begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= r_sd_we ? '0 : sd_rdata;
                        end
                    end else if (r_wdog == c_wd_last) begin
                        // Final allowed grant cycle elapsed without an ack.
                        r_state  <= ST_RESP;
                        r_sd_req <= 1'b0;
                        r_err    <= 1'b1;
                        r_wdog   <= c_wd_max;
                        if (r_state == ST_GRANT_I) begin
                            r_i_ack <= 1'b1;
                        end else begin
                            r_d_ack <= 1'b1;
                        end
                    end else if (r_wdog != c_wd_max) begin
                        r_wdog <= r_wdog + c_wd_one;
                    end
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    r_wdog    <= '0;
                    r_i_ack   <= 1'b0;
                    r_d_ack   <= 1'b0;
                    r_err     <= 1'b0;
                    r_i_rdata <= '0;
                    r_d_rdata <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ack    = r_i_ack;
    assign d_ack    = r_d_ack;
    assign err      = r_err;
    assign i_rdata  = r_i_rdata;
    assign d_rdata  = r_d_rdata;
    assign sd_req   = r_sd_req;
    assign sd_we    = r_sd_we;
    assign sd_addr  = r_sd_addr;
    assign sd_wdata = r_sd_wdata;
    assign sd_mask  = r_sd_mask;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Brief    : Directed, table-driven bench for sdram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int c_aw = 32;
    localparam int c_dw = 32;
    localparam int c_mw = 4;
    localparam int c_to = 8;

    localparam logic [31:0] c_ia  = 32'h4000_0100;
    localparam logic [31:0] c_da  = 32'h4000_0200;
    localparam logic [31:0] c_dwd = 32'h1234_5678;
    localparam logic [3:0]  c_dm  = 4'b0011;

    localparam logic [1:0] c_own_n = 2'd0;
    localparam logic [1:0] c_own_i = 2'd1;
    localparam logic [1:0] c_own_d = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    logic i_req;
    logic [c_aw-1:0] i_addr;
    logic [c_dw-1:0] i_rdata;
    logic i_ack;
    logic d_req;
    logic d_we;
    logic [c_aw-1:0] d_addr;
    logic [c_dw-1:0] d_wdata;
    logic [c_mw-1:0] d_mask;
    logic [c_dw-1:0] d_rdata;
    logic d_ack;
    logic err;
    logic sd_req;
    logic sd_we;
    logic [c_aw-1:0] sd_addr;
    logic [c_dw-1:0] sd_wdata;
    logic [c_mw-1:0] sd_mask;
    logic [c_dw-1:0] sd_rdata;
    logic sd_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W  (c_aw),
        .DATA_W  (c_dw),
        .TIMEOUT (c_to)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_mask   (d_mask),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .err      (err),
        .sd_req   (sd_req),
        .sd_we    (sd_we),
        .sd_addr  (sd_addr),
        .sd_wdata (sd_wdata),
        .sd_mask  (sd_mask),
        .sd_rdata (sd_rdata),
        .sd_ack   (sd_ack)
    );

    // One row = inputs held for one cycle, outputs expected after that edge.
    typedef struct {
        string       nm;
        logic        ireq;
        logic        dreq;
        logic        dwe;
        logic        sack;
        logic [31:0] srd;
        logic        esreq;
        logic [1:0]  eown;
        logic        eiack;
        logic        edack;
        logic        eerr;
        logic [31:0] eird;
        logic [31:0] edrd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic ireq, input logic dreq,
                                input logic dwe, input logic sack, input logic [31:0] srd,
                                input logic esreq, input logic [1:0] eown, input logic eiack,
                                input logic edack, input logic eerr, input logic [31:0] eird,
                                input logic [31:0] edrd);
        vec_t v;
        v.nm = nm; v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.sack = sack; v.srd = srd;
        v.esreq = esreq; v.eown = eown; v.eiack = eiack; v.edack = edack; v.eerr = eerr;
        v.eird = eird; v.edrd = edrd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string nm, input logic esreq, input logic [1:0] eown,
                            input logic eiack, input logic edack, input logic eerr,
                            input logic [31:0] eird, input logic [31:0] edrd, input logic edwe);
        chk({nm, " sd_req"},  sd_req,  esreq);
        chk({nm, " i_ack"},   i_ack,   eiack);
        chk({nm, " d_ack"},   d_ack,   edack);
        chk({nm, " err"},     err,     eerr);
        chk({nm, " i_rdata"}, i_rdata, eird);
        chk({nm, " d_rdata"}, d_rdata, edrd);
        if (esreq) begin
            if (eown == c_own_d) begin
                chk({nm, " sd_we"},    sd_we,    edwe);
                chk({nm, " sd_addr"},  sd_addr,  c_da);
                chk({nm, " sd_wdata"}, sd_wdata, c_dwd);
                chk({nm, " sd_mask"},  sd_mask,  c_dm);
            end else begin
                chk({nm, " sd_we"},    sd_we,    1'b0);
                chk({nm, " sd_addr"},  sd_addr,  c_ia);
                chk({nm, " sd_wdata"}, sd_wdata, 32'h0);
                chk({nm, " sd_mask"},  sd_mask,  4'hF);
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " sd_req"},   sd_req,   1'b0);
        chk({nm, " sd_we"},    sd_we,    1'b0);
        chk({nm, " sd_addr"},  sd_addr,  32'h0);
        chk({nm, " sd_wdata"}, sd_wdata, 32'h0);
        chk({nm, " sd_mask"},  sd_mask,  4'h0);
        chk({nm, " i_ack"},    i_ack,    1'b0);
        chk({nm, " d_ack"},    d_ack,    1'b0);
        chk({nm, " err"},      err,      1'b0);
        chk({nm, " i_rdata"},  i_rdata,  32'h0);
        chk({nm, " d_rdata"},  d_rdata,  32'h0);
    endtask

    initial begin
        // Contention from reset: D, I, D, I with one idle cycle between.
        vecs.push_back(mk("ct0",  1,1,0,0,32'h0,         1,c_own_d,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("ct1",  1,1,0,1,32'hA0A0_0001, 0,c_own_n,0,1,0,32'h0,32'hA0A0_0001));
        vecs.push_back(mk("ct2",  1,1,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("ct3",  1,1,0,0,32'h0,         1,c_own_i,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("ct4",  1,1,0,1,32'hB1B1_0002, 0,c_own_n,1,0,0,32'hB1B1_0002,32'h0));
        vecs.push_back(mk("ct5",  1,1,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("ct6",  1,1,0,0,32'h0,         1,c_own_d,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("ct7",  1,1,0,1,32'hC2C2_0003, 0,c_own_n,0,1,0,32'h0,32'hC2C2_0003));
        vecs.push_back(mk("ct8",  1,1,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("ct9",  1,1,0,0,32'h0,         1,c_own_i,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("ct10", 1,1,0,1,32'hD3D3_0004, 0,c_own_n,1,0,0,32'hD3D3_0004,32'h0));
        vecs.push_back(mk("ct11", 1,1,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("ct12", 0,0,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        // Single fetch, controller acks on the fourth sd_req cycle.
        vecs.push_back(mk("f0",   1,0,0,0,32'h0,         1,c_own_i,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("f1",   1,0,0,0,32'h0,         1,c_own_i,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("f2",   1,0,0,0,32'h0,         1,c_own_i,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("f3",   1,0,0,0,32'h0,         1,c_own_i,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("f4",   1,0,0,1,32'hDEAD_BEEF, 0,c_own_n,1,0,0,32'hDEAD_BEEF,32'h0));
        vecs.push_back(mk("f5",   1,0,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("f6",   0,0,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        // Data write; controller returns junk read data that must be discarded.
        vecs.push_back(mk("w0",   0,1,1,0,32'h0,         1,c_own_d,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("w1",   0,1,1,0,32'h0,         1,c_own_d,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("w2",   0,1,1,1,32'hFFFF_FFFF, 0,c_own_n,0,1,0,32'h0,32'h0));
        vecs.push_back(mk("w3",   0,1,1,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("w4",   0,0,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));
        // Stray sd_ack while idle.
        vecs.push_back(mk("sa0",  0,0,0,1,32'h5555_5555, 0,c_own_n,0,0,0,32'h0,32'h0));
        vecs.push_back(mk("sa1",  0,0,0,0,32'h0,         0,c_own_n,0,0,0,32'h0,32'h0));

        rst_n    = 1'b0;
        i_req    = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        i_addr   = c_ia;
        d_addr   = c_da;
        d_wdata  = c_dwd;
        d_mask   = c_dm;
        sd_ack   = 1'b0;
        sd_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #2 rst_n = 1'b1;

        foreach (vecs[k]) begin
            i_req    = vecs[k].ireq;
            d_req    = vecs[k].dreq;
            d_we     = vecs[k].dwe;
            sd_ack   = vecs[k].sack;
            sd_rdata = vecs[k].srd;
            step();
            chk_outs(vecs[k].nm, vecs[k].esreq, vecs[k].eown, vecs[k].eiack, vecs[k].edack,
                     vecs[k].eerr, vecs[k].eird, vecs[k].edrd, vecs[k].dwe);
        end
        sd_ack   = 1'b0;
        sd_rdata = '0;

        // Timeout: controller never acks a fetch.
        i_req = 1'b1;
        for (int k = 1; k <= c_to; k++) begin
            step();
            chk($sformatf("to grant%0d sd_req", k), sd_req, 1'b1);
            chk($sformatf("to grant%0d i_ack", k),  i_ack,  1'b0);
        end
        step();
        chk("to resp sd_req",  sd_req,  1'b0);
        chk("to resp i_ack",   i_ack,   1'b1);
        chk("to resp err",     err,     1'b1);
        chk("to resp i_rdata", i_rdata, 32'h0);
        chk("to resp d_ack",   d_ack,   1'b0);
        step();
        chk("to idle i_ack", i_ack, 1'b0);
        chk("to idle err",   err,   1'b0);
        i_req = 1'b0;
        d_req = 1'b1;
        d_we  = 1'b0;
        step();
        chk("to next sd_req",  sd_req,  1'b1);
        chk("to next sd_addr", sd_addr, c_da);
        chk("to next sd_we",   sd_we,   1'b0);
        sd_ack   = 1'b1;
        sd_rdata = 32'h600D_F00D;
        step();
        chk("to next d_ack",   d_ack,   1'b1);
        chk("to next d_rdata", d_rdata, 32'h600D_F00D);
        chk("to next err",     err,     1'b0);
        chk("to next i_ack",   i_ack,   1'b0);
        sd_ack = 1'b0;
        step();
        d_req = 1'b0;

        // Coincidence: sd_ack lands on the last allowed grant cycle.
        i_req = 1'b1;
        step();
        repeat (c_to - 1) step();
        chk("co last sd_req", sd_req, 1'b1);
        sd_ack   = 1'b1;
        sd_rdata = 32'hC0FF_EE11;
        step();
        chk("co i_ack",   i_ack,   1'b1);
        chk("co err",     err,     1'b0);
        chk("co i_rdata", i_rdata, 32'hC0FF_EE11);
        chk("co sd_req",  sd_req,  1'b0);
        sd_ack = 1'b0;
        step();
        i_req = 1'b0;
        chk("co idle i_ack", i_ack, 1'b0);

        // Reset mid-grant of a data write, then contention must go to D.
        d_req = 1'b1;
        d_we  = 1'b1;
        step();
        chk("rs grant sd_req", sd_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rs async");
        i_req = 1'b1;
        d_req = 1'b1;
        d_we  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rs first sd_req",  sd_req,  1'b1);
        chk("rs first sd_addr", sd_addr, c_da);
        sd_ack   = 1'b1;
        sd_rdata = 32'h0BAD_CAFE;
        step();
        chk("rs first d_ack",   d_ack,   1'b1);
        chk("rs first d_rdata", d_rdata, 32'h0BAD_CAFE);
        chk("rs first i_ack",   i_ack,   1'b0);
        sd_ack = 1'b0;
        step();
        step();
        chk("rs second sd_req",  sd_req,  1'b1);
        chk("rs second sd_addr", sd_addr, c_ia);
        i_req  = 1'b0;
        d_req  = 1'b0;
        sd_ack = 1'b1;
        sd_rdata = 32'h1111_2222;
        step();
        chk("rs second i_ack",   i_ack,   1'b1);
        chk("rs second i_rdata", i_rdata, 32'h1111_2222);
        sd_ack = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port arbiter that shares the single SDRAM controller port between the instruction-fetch path and the data path. Both paths can target SDRAM-resident code and data. It sits between the core-side bus and the SDRAM controller. It serialises requests, applies round-robin when both ports contend, captures each transaction's command, and returns the read word and a completion pulse to the owning port. A watchdog converts a hung SDRAM transaction into an error completion so the core never stalls forever.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; the mask is `DATA_W/8` bits.
- `TIMEOUT`, default 255: maximum cycles a granted transaction waits for `sd_ack` before it is aborted.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_req`  in  1  instruction fetch request; held with stable `i_addr` until `i_ack`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_rdata`  out  DATA_W  fetched word; valid only while `i_ack`=1.
- `i_ack`  out  1  one-cycle completion pulse to the fetch port.
- `d_req`  in  1  data request; held with stable command until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write data.
- `d_mask`  in  DATA_W/8  byte enables.
- `d_rdata`  out  DATA_W  read word; valid only while `d_ack`=1.
- `d_ack`  out  1  one-cycle completion pulse to the data port.
- `err`  out  1  high together with `i_ack`/`d_ack` when the transaction timed out.
- `sd_req`  out  1  request to the SDRAM controller; held until `sd_ack`.
- `sd_we`, `sd_addr`, `sd_wdata`, `sd_mask`  out  1/ADDR_W/DATA_W/DATA_W/8  registered command; stable while `sd_req`=1.
- `sd_rdata`  in  DATA_W  controller read data; valid with `sd_ack`.
- `sd_ack`  in  1  controller completion pulse.

## Operation
- FSM states:
  - IDLE → GRANT_I / GRANT_D on a sampled request.
  - GRANT_x → RESP on `sd_ack` or on timeout.
  - RESP → IDLE, unconditionally after one cycle.
- Requests are sampled only in IDLE. Address decode happens upstream; the ports raise a request only for SDRAM addresses.
- Arbitration in IDLE:
  - Only one request pending: that port is granted.
  - Both pending: the port not granted last time wins. `last_grant` resets to I, so D wins the first contention.
- On grant, `sd_we`/`sd_addr`/`sd_wdata`/`sd_mask` are loaded from the winning port.
  - Fetch grants drive `sd_we`=0, `sd_mask`=all ones, `sd_wdata`=0.
- On `sd_ack`, `sd_rdata` is registered into the owner's rdata output; the owner's ack is pulsed in RESP.
  - Write transactions return rdata=0.
- Watchdog: counts cycles in GRANT_x. When the count reaches `TIMEOUT` without `sd_ack`:
  - `sd_req` drops;
  - RESP asserts ack, `err`=1 and rdata=0.
  - If `sd_ack` and timeout coincide, `sd_ack` wins and `err`=0.
- Non-owner ack/rdata outputs stay 0 at all times.

## Timing
- Reset values: all outputs 0, state IDLE, watchdog counter 0, `last_grant`=I. Asserting `rst_n` low mid-transaction clears everything immediately, including `sd_req`. The SDRAM controller tolerates an abandoned request.
- Request latency:
  - Request high in IDLE at cycle N → `sd_req`=1 at N+1.
  - `sd_ack` at cycle M → ack pulse at M+1 (RESP) → IDLE at M+2.
  - Minimum turnaround is therefore 3 cycles plus controller latency.
- Handshake: the requester updates or drops its request on the edge ending the ack cycle. A request seen high in IDLE is always a new transaction.
- Back-to-back contention: I and D both held high → grants alternate D, I, D, … with one IDLE cycle between transactions.
- `sd_ack` outside GRANT_x is ignored.
- Watchdog width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Structure
- Shared package `sdram_arb_pkg` holds:
  - the FSM state enum (IDLE, GRANT_I, GRANT_D, RESP);
  - the grant/owner enum (I, D);
  - the default `TIMEOUT` constant.
- Single module with no sub-modules. The arbiter, command register and watchdog together are under 250 lines and are tightly coupled through the FSM.

## Test plan
- Single fetch: `i_req`, `i_addr`=0x4000_0100; controller acks after 4 cycles with 0xDEAD_BEEF.
  - Required: `sd_req` one cycle after the request; `i_ack`=1 with `i_rdata`=0xDEAD_BEEF exactly one cycle after `sd_ack`; `d_ack` stays 0.
- Data write: `d_we`=1, `d_addr`=0x4000_0200, `d_wdata`=0x1234_5678, `d_mask`=4'b0011.
  - Required: `sd_*` carries exactly these values for the whole `sd_req` window; `d_ack` pulses once; `d_rdata`=0.
- Contention: both requests held high for 4 transactions.
  - Required: grant order D, I, D, I; each ack is a single cycle; one IDLE cycle between transactions.
- Timeout: `TIMEOUT`=8, controller never acks.
  - Required: `sd_req` drops after 8 grant cycles; the owner's ack and `err`=1 on the next cycle; rdata=0; the next request is still served.
- Coincidence: `sd_ack` arrives exactly on the timeout cycle.
  - Required: normal completion, `err`=0, `sd_rdata` returned.
- Reset mid-grant: drop `rst_n` while `sd_req`=1.
  - Required: all outputs 0 asynchronously; after release, the first contention is granted to D.
